// File: rtl/polymul_stream_if.sv
// -----------------------------------------------------------------------------
// polymul_stream_if
//   Handshake bundle between the stream driver and the NTT polynomial
//   multiplier. The input side carries one A/B coefficient pair per beat; the
//   output side returns one result coefficient per beat.
//
//   Signals
//     m_in0_valid / m_in1_valid : driver -> multiplier, operand pair valid
//     m_poly_in0 / m_poly_in1   : driver -> multiplier, A and B coefficients
//     m_in_ready                : multiplier -> driver, operand beat accepted
//     m_out_valid               : multiplier -> driver, result coefficient valid
//     m_poly_out                : multiplier -> driver, result coefficient
//     m_out_ready               : driver -> multiplier, result beat accepted
//
//   Modports
//     master : the stream driver side
//     slave  : the multiplier side
// -----------------------------------------------------------------------------
interface polymul_stream_if #(
    parameter int LOGQ = 5
);
    logic            m_in0_valid;
    logic            m_in1_valid;
    logic [LOGQ-1:0] m_poly_in0;
    logic [LOGQ-1:0] m_poly_in1;
    logic            m_in_ready;
    logic            m_out_valid;
    logic [LOGQ-1:0] m_poly_out;
    logic            m_out_ready;

    modport master (
        output m_in0_valid,
        output m_in1_valid,
        output m_poly_in0,
        output m_poly_in1,
        input  m_in_ready,
        input  m_out_valid,
        input  m_poly_out,
        output m_out_ready
    );

    modport slave (
        input  m_in0_valid,
        input  m_in1_valid,
        input  m_poly_in0,
        input  m_poly_in1,
        output m_in_ready,
        output m_out_valid,
        output m_poly_out,
        input  m_out_ready
    );
endinterface

// File: rtl/polymul_stream_driver.sv
// -----------------------------------------------------------------------------
// polymul_stream_driver
//   Stream initiator/collector for the NTT polynomial multiplier. The host
//   fills operand buffers A and B, pulses start, and the block streams the N
//   coefficient pairs into the multiplier, collects the N result coefficients
//   into buffer R, and reports done/err plus the transaction latency. R is
//   exposed through a registered read port. The modulus q is applied by the
//   multiplier; operands are stored and forwarded exactly as written.
//
//   Parameters
//     N        coefficients per polynomial (2**LOGN)
//     LOGQ     coefficient width
//     LOGN     coefficient index width
//     TIMEOUT  max COLLECT cycles without a capture before err
//
//   Ports
//     clk, reset_n          clock, asynchronous active-low reset
//     wr_en/wr_sel/wr_addr/wr_data  host operand write (sel 0 = A, 1 = B), IDLE only
//     start                 single-cycle transaction request, IDLE only
//     hold_out              host backpressure on the result stream
//     rd_addr / rd_data     result read, one cycle latency
//     busy, done, err       status; done/err are sticky until the next start
//     lat_cycles            busy cycles of the last transaction, saturating
//     m                     multiplier handshake bundle (master side)
// -----------------------------------------------------------------------------
module polymul_stream_driver #(
    parameter int N       = 8,
    parameter int LOGQ    = 5,
    parameter int LOGN    = 3,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [LOGN-1:0]  wr_addr,
    input  logic [LOGQ-1:0]  wr_data,
    input  logic             start,
    input  logic             hold_out,
    input  logic [LOGN-1:0]  rd_addr,
    output logic [LOGQ-1:0]  rd_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      lat_cycles,
    polymul_stream_if.master m
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_COLLECT = 2'd2
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [LOGN-1:0] IDX_ZERO = '0;
    localparam logic [LOGN-1:0] IDX_ONE  = LOGN'(1);
    localparam logic [LOGN-1:0] IDX_LAST = LOGN'(N - 1);
    localparam logic [TW-1:0]   TMO_ZERO = '0;
    localparam logic [TW-1:0]   TMO_ONE  = TW'(1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [15:0]     LAT_MAX  = 16'hFFFF;

    // Operand and result buffers. They are deliberately left out of reset so
    // a host can reuse loaded operands after an abort.
    logic [LOGQ-1:0] a_mem [N];
    logic [LOGQ-1:0] b_mem [N];
    logic [LOGQ-1:0] r_mem [N];

    state_t          state_q,    state_d;
    logic [LOGN-1:0] send_idx_q, send_idx_d;
    logic [LOGN-1:0] rcv_idx_q,  rcv_idx_d;
    logic [TW-1:0]   tmo_q,      tmo_d;
    logic [15:0]     lat_q,      lat_d;
    logic            done_q,     done_d;
    logic            err_q,      err_d;
    logic [LOGQ-1:0] rd_data_q,  rd_data_d;

    logic in_valid;
    logic out_ready;
    logic host_wr;
    logic cap_fire;

    // Valid is a pure function of state so a multiplier whose in_ready looks
    // at valid can never form a combinational loop through this block.
    assign in_valid  = (state_q == ST_SEND);
    assign out_ready = (state_q == ST_COLLECT) && !hold_out;
    assign host_wr   = wr_en && (state_q == ST_IDLE);
    assign cap_fire  = out_ready && m.m_out_valid;

    assign m.m_in0_valid = in_valid;
    assign m.m_in1_valid = in_valid;
    assign m.m_poly_in0  = a_mem[send_idx_q];
    assign m.m_poly_in1  = b_mem[send_idx_q];
    assign m.m_out_ready = out_ready;

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign lat_cycles = lat_q;
    assign rd_data    = rd_data_q;

    // Next-state and bookkeeping.
    always_comb begin
        state_d    = state_q;
        send_idx_d = send_idx_q;
        rcv_idx_d  = rcv_idx_q;
        tmo_d      = tmo_q;
        lat_d      = lat_q;
        done_d     = done_q;
        err_d      = err_q;
        rd_data_d  = r_mem[rd_addr];

        if ((state_q != ST_IDLE) && (lat_q != LAT_MAX)) begin
            lat_d = lat_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SEND;
                    send_idx_d = IDX_ZERO;
                    rcv_idx_d  = IDX_ZERO;
                    tmo_d      = TMO_ZERO;
                    lat_d      = 16'd0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end
            end

            ST_SEND: begin
                if (m.m_in_ready) begin
                    send_idx_d = send_idx_q + IDX_ONE;
                    if (send_idx_q == IDX_LAST) begin
                        state_d = ST_COLLECT;
                        tmo_d   = TMO_ZERO;
                    end
                end
            end

            ST_COLLECT: begin
                if (cap_fire) begin
                    rcv_idx_d = rcv_idx_q + IDX_ONE;
                    tmo_d     = TMO_ZERO;
                    if (rcv_idx_q == IDX_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Held-off cycles count too: a host that stalls the
                    // result stream too long is treated like a dead multiplier.
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    done_d  = 1'b0;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            send_idx_q <= IDX_ZERO;
            rcv_idx_q  <= IDX_ZERO;
            tmo_q      <= TMO_ZERO;
            lat_q      <= 16'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            send_idx_q <= send_idx_d;
            rcv_idx_q  <= rcv_idx_d;
            tmo_q      <= tmo_d;
            lat_q      <= lat_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Buffer writes. A host write issued together with start lands at the
    // same edge that enters SEND, so the first beat already sees it.
    always_ff @(posedge clk) begin
        if (host_wr && !wr_sel) begin
            a_mem[wr_addr] <= wr_data;
        end
        if (host_wr && wr_sel) begin
            b_mem[wr_addr] <= wr_data;
        end
        if (cap_fire) begin
            r_mem[rcv_idx_q] <= m.m_poly_out;
        end
    end

endmodule

// File: tb/tb_polymul_stream_driver.sv
module tb_polymul_stream_driver;
    localparam int N    = 8;
    localparam int LOGQ = 5;
    localparam int LOGN = 3;
    localparam int Q    = 17;
    localparam int TMO  = 64;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            wr_en;
    logic            wr_sel;
    logic [LOGN-1:0] wr_addr;
    logic [LOGQ-1:0] wr_data;
    logic            start;
    logic            hold_out;
    logic [LOGN-1:0] rd_addr;
    logic [LOGQ-1:0] rd_data;
    logic            busy;
    logic            done;
    logic            err;
    logic [15:0]     lat_cycles;

    polymul_stream_if #(.LOGQ(LOGQ)) mif ();

    polymul_stream_driver #(.N(N), .LOGQ(LOGQ), .LOGN(LOGN), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .hold_out   (hold_out),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .lat_cycles (lat_cycles),
        .m          (mif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Multiplier stub state
    int in_mode  = 0;   // 0 always ready, 1 alternate cycles, 2 random
    int out_mode = 2;   // 0 random valid gaps, 1 never valid, 2 always valid
    int rx_a[$];
    int rx_b[$];
    int out_q[$];
    bit ov_state = 1'b0;
    bit stall_pending = 1'b0;
    logic [LOGQ-1:0] stall_a, stall_b;
    int cap_cnt = 0;
    int last_cap_edge = -1000;
    int in_last_edge  = -1000;

    // Host-side reference
    int a_ref[N];
    int b_ref[N];
    int r_exp[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Negacyclic product: result = a*b mod (x^N + 1, Q)
    function automatic void negmul(input int a[N], input int b[N], output int r[N]);
        int acc[N];
        for (int k = 0; k < N; k++) acc[k] = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (i + j < N) acc[i+j]   += a[i] * b[j];
                else           acc[i+j-N] -= a[i] * b[j];
            end
        end
        for (int k = 0; k < N; k++) r[k] = ((acc[k] % Q) + Q) % Q;
    endfunction

    // Stub: handshakes resolved at the active edge
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_a.delete();
            rx_b.delete();
            out_q.delete();
            ov_state      = 1'b0;
            stall_pending = 1'b0;
            cap_cnt       = 0;
        end else begin
            if (stall_pending) begin
                chk("send_hold_valid", mif.m_in0_valid, 1);
                chk("send_hold_data0", mif.m_poly_in0, stall_a);
                chk("send_hold_data1", mif.m_poly_in1, stall_b);
            end
            if (mif.m_in0_valid && mif.m_in_ready) begin
                chk("valid_pair", mif.m_in1_valid, 1);
                rx_a.push_back(int'(mif.m_poly_in0));
                rx_b.push_back(int'(mif.m_poly_in1));
                if (rx_a.size() == N) begin
                    int ta[N];
                    int tbv[N];
                    int tr[N];
                    for (int k = 0; k < N; k++) begin
                        ta[k]  = rx_a[k];
                        tbv[k] = rx_b[k];
                    end
                    negmul(ta, tbv, tr);
                    for (int k = 0; k < N; k++) out_q.push_back(tr[k]);
                    in_last_edge = cyc;
                end
            end
            stall_pending = mif.m_in0_valid && !mif.m_in_ready;
            stall_a = mif.m_poly_in0;
            stall_b = mif.m_poly_in1;
            if (mif.m_out_valid && mif.m_out_ready && out_q.size() != 0) begin
                void'(out_q.pop_front());
                cap_cnt++;
                last_cap_edge = cyc;
                ov_state = 1'b0;
            end
            cyc++;
        end
    end

    // Stub: drive multiplier outputs away from the active edge
    always @(negedge clk) begin
        case (in_mode)
            0:       mif.m_in_ready = 1'b1;
            1:       mif.m_in_ready = cyc[0];
            default: mif.m_in_ready = 1'($urandom_range(0, 1));
        endcase
        if (!ov_state && out_q.size() != 0 && out_mode != 1)
            ov_state = (out_mode == 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (out_q.size() == 0) ov_state = 1'b0;
        mif.m_out_valid = ov_state;
        mif.m_poly_out  = (out_q.size() != 0) ? LOGQ'(out_q[0]) : '0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic load_vec();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = LOGN'(i); wr_data = LOGQ'(a_ref[i]);
        end
        for (int i = 0; i < N - 1; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = LOGN'(i); wr_data = LOGQ'(b_ref[i]);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Start with the final B write in the same cycle
    task automatic start_txn(input string tag, output int s);
        @(negedge clk);
        rx_a.delete(); rx_b.delete(); out_q.delete();
        cap_cnt = 0; ov_state = 1'b0;
        in_last_edge = -1000; last_cap_edge = -1000;
        start = 1'b1;
        wr_en = 1'b1; wr_sel = 1'b1; wr_addr = LOGN'(N - 1); wr_data = LOGQ'(b_ref[N-1]);
        s = cyc;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        chk($sformatf("%s_busy_after_start", tag), busy, 1);
        chk($sformatf("%s_done_cleared", tag), done, 0);
        chk($sformatf("%s_err_cleared", tag), err, 0);
    endtask

    task automatic finish_txn(input string tag, input int s, input int hold_after);
        int n;
        bit held;
        n = 0; held = 1'b0;
        while (!(done === 1'b1 || err === 1'b1) && n < 3000) begin
            if (hold_after != 0 && !held && cap_cnt == hold_after) begin
                held = 1'b1;
                hold_out = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    #1;
                    chk($sformatf("%s_ready_low%0d", tag, k), mif.m_out_ready, 0);
                    @(negedge clk);
                end
                hold_out = 1'b0;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        chk($sformatf("%s_done", tag), done, 1);
        chk($sformatf("%s_err", tag), err, 0);
        chk($sformatf("%s_busy", tag), busy, 0);
        chk($sformatf("%s_captures", tag), cap_cnt, N);
        chk($sformatf("%s_lat", tag), {16'd0, lat_cycles}, 32'(last_cap_edge - s));
        chk($sformatf("%s_beats", tag), rx_a.size(), N);
        if (rx_a.size() == N) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("%s_beat%0d_a", tag, i), rx_a[i], a_ref[i]);
                chk($sformatf("%s_beat%0d_b", tag, i), rx_b[i], b_ref[i]);
            end
        end
        negmul(a_ref, b_ref, r_exp);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            rd_addr = LOGN'(i);
            @(negedge clk);
            chk($sformatf("%s_R%0d", tag, i), rd_data, r_exp[i]);
        end
    endtask

    task automatic set_t1();
        int bv[N];
        bv = '{3, 5, 7, 0, 0, 0, 0, 2};
        for (int i = 0; i < N; i++) begin
            a_ref[i] = (i == 0) ? 1 : 0;
            b_ref[i] = bv[i];
        end
    endtask

    task automatic set_rand();
        for (int i = 0; i < N; i++) begin
            a_ref[i] = int'($urandom_range(0, 31));
            b_ref[i] = int'($urandom_range(0, 31));
        end
    endtask

    initial begin
        int s;
        int lat1;
        int n;
        int err_cyc;

        reset_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; hold_out = 1'b0; rd_addr = '0;
        in_mode = 0; out_mode = 2;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_lat", lat_cycles, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_in0_valid", mif.m_in0_valid, 0);
        chk("rst_in1_valid", mif.m_in1_valid, 0);
        chk("rst_out_ready", mif.m_out_ready, 0);
        reset_n = 1'b1;

        // Test 1: A = 1
        set_t1();
        load_vec();
        start_txn("t1", s);
        // Write while busy must be dropped (targets a beat not yet sent)
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = LOGN'(N - 1); wr_data = ~LOGQ'(a_ref[N-1]);
        @(negedge clk);
        wr_en = 1'b0;
        finish_txn("t1", s, 0);
        lat1 = int'(lat_cycles);
        chk("t1_lat_const", lat_cycles, 16);

        // Test 2: x * x^7 = -1
        for (int i = 0; i < N; i++) begin
            a_ref[i] = (i == 1) ? 1 : 0;
            b_ref[i] = (i == N - 1) ? 1 : 0;
        end
        load_vec();
        start_txn("t2", s);
        finish_txn("t2", s, 0);

        // Test 3: test 1 with 5 held cycles after the 3rd capture
        set_t1();
        load_vec();
        start_txn("t3", s);
        finish_txn("t3", s, 3);
        chk("t3_lat_plus5", lat_cycles, 32'(lat1 + 5));

        // Test 4: multiplier never returns data
        out_mode = 1;
        set_rand();
        load_vec();
        start_txn("t4", s);
        n = 0;
        while (err !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        err_cyc = cyc;
        chk("t4_err", err, 1);
        chk("t4_done", done, 0);
        chk("t4_busy", busy, 0);
        chk("t4_err_time", err_cyc, 32'(in_last_edge + TMO + 1));

        // Test 5: in_ready on alternate cycles
        in_mode = 1; out_mode = 2;
        set_rand();
        load_vec();
        start_txn("t5", s);
        finish_txn("t5", s, 0);

        // Random backpressure on both sides
        in_mode = 2; out_mode = 0;
        for (int it = 0; it < 3; it++) begin
            set_rand();
            load_vec();
            start_txn($sformatf("rnd%0d", it), s);
            finish_txn($sformatf("rnd%0d", it), s, 0);
        end

        // Test 6: ignored start mid-SEND, then reset mid-COLLECT
        in_mode = 0; out_mode = 1;
        set_t1();
        load_vec();
        start_txn("t6", s);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_busy_mid_send", busy, 1);
        n = 0;
        while (rx_a.size() < N && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("t6_beats_once", rx_a.size(), N);
        chk("t6_in_collect", busy, 1);
        chk("t6_out_ready_collect", mif.m_out_ready, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_arst_busy", busy, 0);
        chk("t6_arst_done", done, 0);
        chk("t6_arst_err", err, 0);
        chk("t6_arst_lat", lat_cycles, 0);
        chk("t6_arst_rd_data", rd_data, 0);
        chk("t6_arst_in0_valid", mif.m_in0_valid, 0);
        chk("t6_arst_in1_valid", mif.m_in1_valid, 0);
        chk("t6_arst_out_ready", mif.m_out_ready, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        out_mode = 2;
        // Buffers survive reset: no reload
        start_txn("t6r", s);
        finish_txn("t6r", s, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
